instr_encoder: RTL and testbench

//  Inverse of the ID-stage field decoder. Packs decoded RV32I fields into 32-bit instruction

---
 rtl/rv32_pkg.sv | 26 ++
 rtl/sync_fifo.sv | 58 +++++
 rtl/instr_encoder.sv | 132 +++++++++++++
 tb/tb_instr_encoder.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/rv32_pkg.sv
// Shared RV32I definitions: 5-bit major opcodes (instruction[6:2]) and the
// encoder FSM state type. Also used by the decoder/controller side.
package rv32_pkg;

  localparam logic [4:0] LOAD   = 5'b00000;
  localparam logic [4:0] OP_IMM = 5'b00100;
  localparam logic [4:0] AUIPC  = 5'b00101;
  localparam logic [4:0] STORE  = 5'b01000;
  localparam logic [4:0] OP     = 5'b01100;
  localparam logic [4:0] LUI    = 5'b01101;
  localparam logic [4:0] BRANCH = 5'b11000;
  localparam logic [4:0] JALR   = 5'b11001;
  localparam logic [4:0] JAL    = 5'b11011;

  // func3 values that select the shift-immediate layout inside OP_IMM
  localparam logic [2:0] F3_SLLI = 3'b001;
  localparam logic [2:0] F3_SRXI = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } enc_state_t;

endpackage

// File: rtl/sync_fifo.sv
// Small synchronous FIFO with a combinational head read so a word pushed
// into an empty FIFO is presented on the very next cycle. Push into a full
// FIFO and pop from an empty FIFO are ignored; push+pop together keep
// occupancy unchanged.
module sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             i_clr,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_din,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_dout,
  output logic             o_full,
  output logic             o_empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic             w_push;
  logic             w_pop;

  assign o_full  = (r_count == (AW+1)'(DEPTH));
  assign o_empty = (r_count == '0);
  assign w_push  = i_push && !o_full;
  assign w_pop   = i_pop && !o_empty;
  assign o_dout  = r_mem[r_rd_ptr];

  // Storage array; contents need no reset, the pointers define validity.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= i_din;
    end
  end

  // Pointer and occupancy bookkeeping with synchronous flush.
  always_ff @(posedge clk) begin
    if (i_clr) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/instr_encoder.sv
// Packs decoded RV32I fields into 32-bit instruction words and streams them
// into instruction memory at consecutive word addresses through a FIFO.
// Illegal opcodes are consumed and counted but never written.
module instr_encoder
  import rv32_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int ADDR_W     = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_last,
  input  logic [4:0]        opcode_5bit,
  input  logic [2:0]        func3,
  input  logic              func7_1bit,
  input  logic [4:0]        rs1_index,
  input  logic [4:0]        rs2_index,
  input  logic [4:0]        rd_index,
  input  logic [31:0]       imm,
  output logic              im_we,
  input  logic              im_ready,
  output logic [ADDR_W-1:0] im_addr,
  output logic [31:0]       im_din,
  output logic              done,
  output logic [15:0]       word_cnt,
  output logic [7:0]        err_cnt
);

  enc_state_t        r_state;
  logic [ADDR_W-1:0] r_addr;
  logic [15:0]       r_word_cnt;
  logic [7:0]        r_err_cnt;

  logic [31:0] w_word;
  logic        w_legal;
  logic        w_accept;
  logic        w_write;
  logic        w_fifo_full;
  logic        w_fifo_empty;
  logic [31:0] w_fifo_head;
  logic        w_write_phase;

  // Combinational field packer; bits[1:0] are always 2'b11 for RV32I.
  always_comb begin
    w_legal = 1'b1;
    w_word  = '0;
    case (opcode_5bit)
      OP:
        w_word = {1'b0, func7_1bit, 5'b0, rs2_index, rs1_index, func3, rd_index, opcode_5bit, 2'b11};
      LOAD, JALR:
        w_word = {imm[11:0], rs1_index, func3, rd_index, opcode_5bit, 2'b11};
      OP_IMM:
        if (func3 == F3_SLLI || func3 == F3_SRXI)
          w_word = {1'b0, func7_1bit, 5'b0, imm[4:0], rs1_index, func3, rd_index, opcode_5bit, 2'b11};
        else
          w_word = {imm[11:0], rs1_index, func3, rd_index, opcode_5bit, 2'b11};
      STORE:
        w_word = {imm[11:5], rs2_index, rs1_index, func3, imm[4:0], opcode_5bit, 2'b11};
      BRANCH:
        w_word = {imm[12], imm[10:5], rs2_index, rs1_index, func3, imm[4:1], imm[11], opcode_5bit, 2'b11};
      LUI, AUIPC:
        w_word = {imm[31:12], rd_index, opcode_5bit, 2'b11};
      JAL:
        w_word = {imm[20], imm[10:1], imm[11], imm[19:12], rd_index, opcode_5bit, 2'b11};
      default:
        w_legal = 1'b0;
    endcase
  end

  // A full FIFO blocks acceptance even when a pop happens the same cycle.
  assign in_ready      = (r_state == ST_RUN) && !w_fifo_full;
  assign w_accept      = in_valid && in_ready;
  assign w_write_phase = (r_state == ST_RUN) || (r_state == ST_DRAIN);
  assign im_we         = w_write_phase && !w_fifo_empty;
  assign w_write       = im_we && im_ready;
  assign im_din        = im_we ? w_fifo_head : 32'h0;
  assign im_addr       = r_addr;
  assign done          = (r_state == ST_DONE);
  assign word_cnt      = r_word_cnt;
  assign err_cnt       = r_err_cnt;

  sync_fifo #(
    .WIDTH (32),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .i_clr   (rst),
    .i_push  (w_accept && w_legal),
    .i_din   (w_word),
    .i_pop   (w_write),
    .o_dout  (w_fifo_head),
    .o_full  (w_fifo_full),
    .o_empty (w_fifo_empty)
  );

  // Program sequencing FSM plus the address pointer and saturating counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_addr     <= '0;
      r_word_cnt <= '0;
      r_err_cnt  <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_state    <= ST_RUN;
            r_addr     <= base_addr;
            r_word_cnt <= '0;
            r_err_cnt  <= '0;
          end
        end
        ST_RUN:   if (w_accept && in_last) r_state <= ST_DRAIN;
        ST_DRAIN: if (w_fifo_empty) r_state <= ST_DONE;
        default:  r_state <= ST_IDLE;
      endcase
      // Writes only occur in RUN/DRAIN, so these never collide with the IDLE load.
      if (w_write) begin
        r_addr <= r_addr + ADDR_W'(4);
        if (r_word_cnt != 16'hFFFF) r_word_cnt <= r_word_cnt + 16'd1;
      end
      if (w_accept && !w_legal && r_err_cnt != 8'hFF) begin
        r_err_cnt <= r_err_cnt + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_instr_encoder.sv
// Directed bench for instr_encoder: a vector table of encodings run as
// single-word programs, then hand-written stall, illegal-opcode, wrap and
// reset-during-drain sequences.
module tb_instr_encoder;

  typedef struct {
    logic [4:0]  opc;
    logic [2:0]  f3;
    logic        f7b;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [31:0] imm;
    logic [31:0] exp;
  } vec_t;

  localparam int NV = 12;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [31:0] base_addr;
  logic        in_valid;
  logic        in_ready;
  logic        in_last;
  logic [4:0]  opcode_5bit;
  logic [2:0]  func3;
  logic        func7_1bit;
  logic [4:0]  rs1_index;
  logic [4:0]  rs2_index;
  logic [4:0]  rd_index;
  logic [31:0] imm;
  logic        im_we;
  logic        im_ready;
  logic [31:0] im_addr;
  logic [31:0] im_din;
  logic        done;
  logic [15:0] word_cnt;
  logic [7:0]  err_cnt;

  int errors = 0;
  int checks = 0;
  int done_cnt = 0;
  logic [31:0] q_addr[$];
  logic [31:0] q_din[$];
  vec_t vecs[NV];
  vec_t ill;

  instr_encoder #(.FIFO_DEPTH(4), .ADDR_W(32)) dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr),
    .in_valid(in_valid), .in_ready(in_ready), .in_last(in_last),
    .opcode_5bit(opcode_5bit), .func3(func3), .func7_1bit(func7_1bit),
    .rs1_index(rs1_index), .rs2_index(rs2_index), .rd_index(rd_index), .imm(imm),
    .im_we(im_we), .im_ready(im_ready), .im_addr(im_addr), .im_din(im_din),
    .done(done), .word_cnt(word_cnt), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  // Record every completed IM write and every done pulse.
  always @(negedge clk) begin
    if (!rst && im_we && im_ready) begin
      q_addr.push_back(im_addr);
      q_din.push_back(im_din);
    end
    if (done) done_cnt++;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end else begin
      $display("ok   %s: 0x%08h", name, act);
    end
  endtask

  task automatic drive(input vec_t v, input logic last);
    opcode_5bit = v.opc; func3 = v.f3; func7_1bit = v.f7b;
    rs1_index = v.rs1; rs2_index = v.rs2; rd_index = v.rd; imm = v.imm;
    in_last = last; in_valid = 1'b1;
  endtask

  task automatic start_prog(input logic [31:0] b);
    @(posedge clk); #1;
    start = 1'b1; base_addr = b;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Present a bundle and hold it until accepted (bounded).
  task automatic send(input vec_t v, input logic last);
    int n;
    n = 0;
    drive(v, last);
    @(negedge clk);
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("accept", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  task automatic wait_done();
    logic got;
    got = 1'b0;
    for (int n = 0; n < 200 && !got; n++) begin
      @(negedge clk);
      if (done) got = 1'b1;
    end
    check("done_pulse", 32'(got), 32'd1);
    @(negedge clk);
    check("done_one_cycle", 32'(done), 32'd0);
  endtask

  task automatic clear_q();
    q_addr.delete();
    q_din.delete();
  endtask

  initial begin
    vecs[0]  = '{5'b01100, 3'b000, 1'b0, 5'd1, 5'd2, 5'd3, 32'h0000_0000, 32'h0020_81B3}; // ADD
    vecs[1]  = '{5'b01100, 3'b000, 1'b1, 5'd1, 5'd2, 5'd3, 32'h0000_0000, 32'h4020_81B3}; // SUB
    vecs[2]  = '{5'b00100, 3'b000, 1'b1, 5'd0, 5'd7, 5'd1, 32'hFFFF_FFFF, 32'hFFF0_0093}; // ADDI -1
    vecs[3]  = '{5'b01000, 3'b010, 1'b0, 5'd1, 5'd2, 5'd9, 32'h0000_0008, 32'h0020_A423}; // SW
    vecs[4]  = '{5'b11000, 3'b000, 1'b0, 5'd0, 5'd0, 5'd0, 32'hFFFF_FFFC, 32'hFE00_0EE3}; // BEQ -4
    vecs[5]  = '{5'b00100, 3'b101, 1'b1, 5'd6, 5'd0, 5'd5, 32'h0000_0003, 32'h4033_5293}; // SRAI
    vecs[6]  = '{5'b01101, 3'b000, 1'b0, 5'd0, 5'd0, 5'd5, 32'h1234_5ABC, 32'h1234_52B7}; // LUI
    vecs[7]  = '{5'b11011, 3'b000, 1'b0, 5'd0, 5'd0, 5'd1, 32'h0000_0801, 32'h0010_00EF}; // JAL
    vecs[8]  = '{5'b00101, 3'b000, 1'b0, 5'd0, 5'd0, 5'd2, 32'hFFFF_F000, 32'hFFFF_F117}; // AUIPC
    vecs[9]  = '{5'b00000, 3'b010, 1'b0, 5'd2, 5'd0, 5'd4, 32'hFFFF_FFF8, 32'hFF81_2203}; // LW -8
    vecs[10] = '{5'b11001, 3'b000, 1'b0, 5'd1, 5'd0, 5'd0, 32'h0000_0000, 32'h0000_8067}; // JALR
    vecs[11] = '{5'b00100, 3'b001, 1'b0, 5'd1, 5'd0, 5'd1, 32'h0000_001F, 32'h01F0_9093}; // SLLI 31
    ill      = '{5'b11111, 3'b000, 1'b0, 5'd1, 5'd1, 5'd1, 32'h0000_0000, 32'h0000_0000};

    rst = 1'b1; start = 1'b0; base_addr = '0; in_valid = 1'b0; in_last = 1'b0;
    opcode_5bit = '0; func3 = '0; func7_1bit = 1'b0; rs1_index = '0; rs2_index = '0;
    rd_index = '0; imm = '0; im_ready = 1'b1;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_im_we", 32'(im_we), 32'd0);
    check("rst_im_addr", im_addr, 32'd0);
    check("rst_im_din", im_din, 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_word_cnt", 32'(word_cnt), 32'd0);
    check("rst_err_cnt", 32'(err_cnt), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Encoding table: each vector as a one-word program
    for (int i = 0; i < NV; i++) begin
      logic [31:0] b;
      b = 32'h100 + 32'(i) * 32'h10;
      clear_q();
      start_prog(b);
      send(vecs[i], 1'b1);
      check($sformatf("v%0d_latency_we", i), 32'(im_we), 32'd1);
      check($sformatf("v%0d_latency_din", i), im_din, vecs[i].exp);
      wait_done();
      check($sformatf("v%0d_nwrites", i), 32'(q_din.size()), 32'd1);
      if (q_din.size() > 0) begin
        check($sformatf("v%0d_addr", i), q_addr[0], b);
        check($sformatf("v%0d_din", i), q_din[0], vecs[i].exp);
      end
      check($sformatf("v%0d_word_cnt", i), 32'(word_cnt), 32'd1);
      check($sformatf("v%0d_err_cnt", i), 32'(err_cnt), 32'd0);
    end

    // Stall: fill the FIFO, 5th bundle blocked, start ignored, then release
    clear_q();
    im_ready = 1'b0;
    start_prog(32'h200);
    for (int k = 0; k < 4; k++) send(vecs[k], 1'b0);
    drive(vecs[4], 1'b1);
    start = 1'b1; base_addr = 32'h0001_2340;
    @(negedge clk);
    check("stall_full_blocks", 32'(in_ready), 32'd0);
    check("stall_we", 32'(im_we), 32'd1);
    check("stall_din", im_din, vecs[0].exp);
    check("stall_addr", im_addr, 32'h200);
    repeat (3) @(negedge clk);
    check("stall_hold_din", im_din, vecs[0].exp);
    check("stall_hold_addr", im_addr, 32'h200);
    @(posedge clk); #1;
    im_ready = 1'b1; start = 1'b0;
    @(negedge clk);
    check("pop_cycle_blocks", 32'(in_ready), 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    check("after_pop_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0; in_last = 1'b0;
    wait_done();
    check("stall_word_cnt", 32'(word_cnt), 32'd5);
    check("stall_nwrites", 32'(q_din.size()), 32'd5);
    for (int k = 0; k < 5 && k < q_din.size(); k++) begin
      check($sformatf("stall_addr%0d", k), q_addr[k], 32'h200 + 32'(k) * 32'd4);
      check($sformatf("stall_din%0d", k), q_din[k], vecs[k].exp);
    end

    // Illegal opcode between legal words, base wraps past 2^32
    clear_q();
    start_prog(32'hFFFF_FFFC);
    send(vecs[0], 1'b0);
    send(ill, 1'b0);
    send(vecs[1], 1'b1);
    wait_done();
    check("ill_err_cnt", 32'(err_cnt), 32'd1);
    check("ill_word_cnt", 32'(word_cnt), 32'd2);
    check("ill_nwrites", 32'(q_din.size()), 32'd2);
    if (q_din.size() == 2) begin
      check("wrap_addr0", q_addr[0], 32'hFFFF_FFFC);
      check("wrap_din0", q_din[0], vecs[0].exp);
      check("wrap_addr1", q_addr[1], 32'h0);
      check("wrap_din1", q_din[1], vecs[1].exp);
    end

    // Illegal opcode carrying in_last still ends the program
    clear_q();
    start_prog(32'h500);
    send(ill, 1'b1);
    wait_done();
    check("ill_last_err_cnt", 32'(err_cnt), 32'd1);
    check("ill_last_word_cnt", 32'(word_cnt), 32'd0);
    check("ill_last_nwrites", 32'(q_din.size()), 32'd0);

    // Reset while draining with three words queued
    clear_q();
    im_ready = 1'b0;
    start_prog(32'h300);
    send(vecs[2], 1'b0);
    send(vecs[3], 1'b0);
    send(vecs[4], 1'b1);
    begin
      int d0;
      d0 = done_cnt;
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      check("mid_rst_we", 32'(im_we), 32'd0);
      check("mid_rst_in_ready", 32'(in_ready), 32'd0);
      check("mid_rst_addr", im_addr, 32'h0);
      check("mid_rst_din", im_din, 32'h0);
      im_ready = 1'b1;
      drive(vecs[0], 1'b0);
      repeat (8) @(negedge clk);
      check("idle_not_accepting", 32'(in_ready), 32'd0);
      check("mid_rst_no_done", 32'(done_cnt), 32'(d0));
      check("mid_rst_nwrites", 32'(q_din.size()), 32'd0);
      @(posedge clk); #1;
      in_valid = 1'b0;
    end
    clear_q();
    start_prog(32'h400);
    send(vecs[5], 1'b1);
    wait_done();
    check("restart_nwrites", 32'(q_din.size()), 32'd1);
    if (q_din.size() > 0) begin
      check("restart_addr", q_addr[0], 32'h400);
      check("restart_din", q_din[0], vecs[5].exp);
    end
    check("restart_word_cnt", 32'(word_cnt), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
